// File: rtl/t_ff_monitor_if.sv
// rtl/t_ff_monitor_if.sv - sample and report bundle between a T flip-flop stage and its monitor
interface t_ff_monitor_if #(
    parameter int CNT_W = 16,
    parameter int WID_W = 8
);
    // Samples of the monitored flop plus the synchronous clear
    logic             clear;
    logic             t_in;
    logic             q_in;
    logic             q_bar_in;

    // Monitor results
    logic [CNT_W-1:0] toggle_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_pulse;
    logic             fault;
    logic [WID_W-1:0] hi_width;
    logic [WID_W-1:0] lo_width;
    logic             width_vld;

    modport master (
        output clear, t_in, q_in, q_bar_in,
        input  toggle_cnt, err_cnt, err_pulse, fault, hi_width, lo_width, width_vld
    );

    modport slave (
        input  clear, t_in, q_in, q_bar_in,
        output toggle_cnt, err_cnt, err_pulse, fault, hi_width, lo_width, width_vld
    );
endinterface

// File: rtl/t_ff_monitor.sv
// rtl/t_ff_monitor.sv - toggle checker, toggle counter and pulse-width meter for a T flip-flop
module t_ff_monitor #(
    parameter int CNT_W  = 16,
    parameter int WID_W  = 8,
    parameter bit STICKY = 1'b1
) (
    input logic          clk,
    input logic          rstn,
    t_ff_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WID_W-1:0] WID_MAX = '1;
    localparam logic [WID_W-1:0] WID_ONE = WID_W'(1);

    state_t           state_q, state_d;
    logic             q_prev_q, q_prev_d;
    logic             t_prev_q, t_prev_d;
    logic             first_run_q, first_run_d;
    logic [WID_W-1:0] run_len_q, run_len_d;
    logic [WID_W-1:0] hi_width_q, hi_width_d;
    logic [WID_W-1:0] lo_width_q, lo_width_d;
    logic             width_vld_q, width_vld_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             fault_q, fault_d;

    logic             cmp_err;
    logic             tog_err;
    logic             chk_err;
    logic             toggled;

    // Checks on the current samples against the previous cycle's Q and t
    always_comb begin
        cmp_err = (mon.q_in == mon.q_bar_in);
        tog_err = (mon.q_in != (q_prev_q ^ t_prev_q));
        chk_err = cmp_err | tog_err;
        toggled = (mon.q_in != q_prev_q);
    end

    // Next-state: clear wins over everything; SYNC only primes history; TRACK/FAULT check and measure
    always_comb begin
        state_d      = state_q;
        q_prev_d     = q_prev_q;
        t_prev_d     = t_prev_q;
        first_run_d  = first_run_q;
        run_len_d    = run_len_q;
        hi_width_d   = hi_width_q;
        lo_width_d   = lo_width_q;
        toggle_cnt_d = toggle_cnt_q;
        err_cnt_d    = err_cnt_q;
        fault_d      = fault_q;
        err_pulse_d  = 1'b0;
        width_vld_d  = 1'b0;

        if (mon.clear) begin
            state_d      = ST_SYNC;
            first_run_d  = 1'b1;
            run_len_d    = WID_ONE;
            hi_width_d   = '0;
            lo_width_d   = '0;
            toggle_cnt_d = '0;
            err_cnt_d    = '0;
            fault_d      = 1'b0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    q_prev_d    = mon.q_in;
                    t_prev_d    = mon.t_in;
                    run_len_d   = WID_ONE;
                    first_run_d = 1'b1;
                    state_d     = ST_TRACK;
                end
                ST_TRACK, ST_FAULT: begin
                    q_prev_d    = mon.q_in;
                    t_prev_d    = mon.t_in;
                    err_pulse_d = chk_err;
                    if (chk_err && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    // FAULT keeps itself by default; only a fresh error can enter it
                    if (STICKY && chk_err) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                    // An unexpected toggle is still a toggle, so it is counted and measured
                    if (toggled) begin
                        if (toggle_cnt_q != CNT_MAX) begin
                            toggle_cnt_d = toggle_cnt_q + CNT_W'(1);
                        end
                        if (first_run_q) begin
                            // The run in progress at sync had an unknown start, so it is not reported
                            first_run_d = 1'b0;
                        end else begin
                            if (q_prev_q) begin
                                hi_width_d = run_len_q;
                            end else begin
                                lo_width_d = run_len_q;
                            end
                            width_vld_d = 1'b1;
                        end
                        run_len_d = WID_ONE;
                    end else if (run_len_q != WID_MAX) begin
                        run_len_d = run_len_q + WID_ONE;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // State and registered outputs; reset leaves the monitor waiting to sync
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_SYNC;
            q_prev_q     <= 1'b0;
            t_prev_q     <= 1'b0;
            first_run_q  <= 1'b1;
            run_len_q    <= '0;
            hi_width_q   <= '0;
            lo_width_q   <= '0;
            width_vld_q  <= 1'b0;
            toggle_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_pulse_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_prev_q     <= q_prev_d;
            t_prev_q     <= t_prev_d;
            first_run_q  <= first_run_d;
            run_len_q    <= run_len_d;
            hi_width_q   <= hi_width_d;
            lo_width_q   <= lo_width_d;
            width_vld_q  <= width_vld_d;
            toggle_cnt_q <= toggle_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_pulse_q  <= err_pulse_d;
            fault_q      <= fault_d;
        end
    end

    assign mon.toggle_cnt = toggle_cnt_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.fault      = fault_q;
    assign mon.hi_width   = hi_width_q;
    assign mon.lo_width   = lo_width_q;
    assign mon.width_vld  = width_vld_q;

endmodule

// File: tb/tb_t_ff_monitor.sv
// tb/tb_t_ff_monitor.sv - directed table-driven bench for t_ff_monitor
module tb_t_ff_monitor;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clear = 1'b0;
    logic t_in = 1'b0;
    logic q_in = 1'b0;
    logic q_bar_in = 1'b1;
    logic q_model = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    t_ff_monitor_if #(.CNT_W(16), .WID_W(8)) ifa ();
    t_ff_monitor_if #(.CNT_W(4),  .WID_W(8)) ifb ();

    assign ifa.clear    = clear;
    assign ifa.t_in     = t_in;
    assign ifa.q_in     = q_in;
    assign ifa.q_bar_in = q_bar_in;
    assign ifb.clear    = clear;
    assign ifb.t_in     = t_in;
    assign ifb.q_in     = q_in;
    assign ifb.q_bar_in = q_bar_in;

    t_ff_monitor #(.CNT_W(16), .WID_W(8), .STICKY(1'b1)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .mon  (ifa)
    );

    t_ff_monitor #(.CNT_W(4), .WID_W(8), .STICKY(1'b0)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .mon  (ifb)
    );

    typedef struct {
        logic t;
        logic flip;
        logic qeq;
        logic clr;
        logic ep;
        logic flt;
        logic wv;
        int   tc;
        int   ec;
        int   hi;
        int   lo;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic t, input logic flip, input logic qeq, input logic clr,
                       input logic ep, input logic flt, input logic wv,
                       input int tc, input int ec, input int hi, input int lo);
        vec_t v;
        v.t = t; v.flip = flip; v.qeq = qeq; v.clr = clr;
        v.ep = ep; v.flt = flt; v.wv = wv;
        v.tc = tc; v.ec = ec; v.hi = hi; v.lo = lo;
        vq.push_back(v);
    endtask

    // Drive one cycle at the falling edge, model the flop at the rising edge, return at the next falling edge
    task automatic step(input logic t, input logic flip, input logic qeq, input logic clr);
        t_in     = t;
        q_in     = q_model ^ flip;
        q_bar_in = qeq ? q_in : ~q_in;
        clear    = clr;
        @(posedge clk);
        q_model = q_in ^ t;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        q_model  = 1'b0;
        t_in     = 1'b0;
        q_in     = 1'b0;
        q_bar_in = 1'b1;
        clear    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_toggle_cnt", 32'(ifa.toggle_cnt), 0);
        check("rst_err_cnt",    32'(ifa.err_cnt),    0);
        check("rst_err_pulse",  32'(ifa.err_pulse),  0);
        check("rst_fault",      32'(ifa.fault),      0);
        check("rst_width_vld",  32'(ifa.width_vld),  0);
        check("rst_hi_width",   32'(ifa.hi_width),   0);
        check("rst_lo_width",   32'(ifa.lo_width),   0);
        rstn = 1'b1;
    endtask

    initial begin
        logic hv;

        //   t flip qeq clr | ep flt wv  tc ec hi lo
        add(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);  // SYNC
        add(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0,  1, 0, 0, 0);  // first toggle, partial run
        add(0, 0, 0, 0,   0, 0, 1,  2, 0, 1, 0);
        add(1, 0, 0, 0,   0, 0, 0,  2, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1,  3, 0, 1, 2);
        add(1, 0, 0, 0,   0, 0, 0,  3, 0, 1, 2);
        add(0, 0, 0, 0,   0, 0, 1,  4, 0, 2, 2);
        add(1, 0, 0, 0,   0, 0, 0,  4, 0, 2, 2);
        add(0, 0, 0, 0,   0, 0, 1,  5, 0, 2, 2);
        add(0, 0, 1, 0,   1, 1, 0,  5, 1, 2, 2);  // q_bar == q
        add(0, 0, 0, 0,   0, 1, 0,  5, 1, 2, 2);  // fault sticks
        add(0, 1, 0, 0,   1, 1, 1,  6, 2, 3, 2);  // unexpected toggle
        add(0, 0, 0, 0,   0, 1, 0,  6, 2, 3, 2);
        add(0, 0, 0, 1,   0, 0, 0,  0, 0, 0, 0);  // clear
        add(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);  // SYNC
        add(1, 1, 0, 1,   0, 0, 0,  0, 0, 0, 0);  // error + toggle with clear
        add(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);  // SYNC
        add(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);

        do_reset();

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].t, vq[i].flip, vq[i].qeq, vq[i].clr);
            check($sformatf("v%0d_err_pulse", i),  32'(ifa.err_pulse),  32'(vq[i].ep));
            check($sformatf("v%0d_fault", i),      32'(ifa.fault),      32'(vq[i].flt));
            check($sformatf("v%0d_width_vld", i),  32'(ifa.width_vld),  32'(vq[i].wv));
            check($sformatf("v%0d_toggle_cnt", i), 32'(ifa.toggle_cnt), 32'(vq[i].tc));
            check($sformatf("v%0d_err_cnt", i),    32'(ifa.err_cnt),    32'(vq[i].ec));
            check($sformatf("v%0d_hi_width", i),   32'(ifa.hi_width),   32'(vq[i].hi));
            check($sformatf("v%0d_lo_width", i),   32'(ifa.lo_width),   32'(vq[i].lo));
            if (i == 11) begin
                check("nonsticky_fault",     32'(ifb.fault),     0);
                check("nonsticky_err_pulse", 32'(ifb.err_pulse), 1);
            end
        end

        // Quiet after reset: SYNC plus 10 tracked cycles with t=0
        do_reset();
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0);
        check("quiet_toggle_cnt", 32'(ifa.toggle_cnt), 0);
        check("quiet_err_cnt",    32'(ifa.err_cnt),    0);
        check("quiet_fault",      32'(ifa.fault),      0);

        // Constant t=1: one toggle per tracked cycle
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        check("t1_toggle_cnt", 32'(ifa.toggle_cnt), 12);
        check("t1_hi_width",   32'(ifa.hi_width),   1);
        check("t1_lo_width",   32'(ifa.lo_width),   1);
        check("t1_err_cnt",    32'(ifa.err_cnt),    0);
        check("t1_width_vld",  32'(ifa.width_vld),  1);
        check("t1_b_toggle",   32'(ifb.toggle_cnt), 12);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check("t1_toggle_cnt_20", 32'(ifa.toggle_cnt), 20);
        check("cnt4_saturate",    32'(ifb.toggle_cnt), 15);

        // Long run saturates the width at 255
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 0);
        hv = q_model;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sat_width_vld",  32'(ifa.width_vld),  1);
        check("sat_width",      hv ? 32'(ifa.hi_width) : 32'(ifa.lo_width), 255);
        check("sat_toggle_cnt", 32'(ifa.toggle_cnt), 2);
        check("sat_err_cnt",    32'(ifa.err_cnt),    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
